// File: rtl/seq_1010_tx.sv
// seq_1010_tx: serial pattern transmitter.
// Sends a frame of repeat_cnt copies of PATTERN, MSB first, with gap_len
// filler bits between consecutive copies. A frame is requested with start
// while ready is high and ends with a one-cycle done pulse. abort cuts a
// frame short without done.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-low reset
//   start      - frame request, sampled only while ready=1
//   repeat_cnt - patterns per frame (latched on accepted start)
//   gap_len    - filler bits between patterns (latched on accepted start)
//   filler     - value of the gap bits (latched on accepted start)
//   abort      - terminate the frame in progress
//   ready      - idle, a start will be accepted
//   d, d_valid - serial data and its qualifier
//   last       - final bit of the final pattern
//   done       - one-cycle pulse after a completed frame
//   pat_cnt    - patterns fully sent in the current or most recent frame
module seq_1010_tx #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int             CNT_W   = 8,
  parameter int             GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             filler,
  input  logic             abort,
  output logic             ready,
  output logic             d,
  output logic             d_valid,
  output logic             last,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] pcnt_inc;

  logic ready_q, ready_d;
  logic d_q, d_d;
  logic d_valid_q, d_valid_d;
  logic last_q, last_d;
  logic done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gcnt_d   = gcnt_q;
    pcnt_d   = pcnt_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    fill_d   = fill_q;
    pcnt_inc = pcnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // abort has no meaning here; only start is looked at
        if (start) begin
          rep_d  = repeat_cnt;
          gap_d  = gap_len;
          fill_d = filler;
          pcnt_d = '0;
          if (repeat_cnt != '0) begin
            idx_d   = IDX_TOP;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          pcnt_d = pcnt_inc;
          if (pcnt_inc == rep_q) begin
            state_d = DONE;
          end else if (gap_q == '0) begin
            idx_d = IDX_TOP;               // back-to-back patterns
          end else begin
            gcnt_d  = gap_q;
            state_d = GAP;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          gcnt_d  = '0;
        end else if (gcnt_q <= GAP_W'(1)) begin
          gcnt_d  = '0;
          idx_d   = IDX_TOP;
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;              // DONE lasts one cycle
    endcase

    // Outputs are computed from the next-state values so they can be
    // registered and still line up with the state they describe.
    ready_d   = (state_d == IDLE);
    d_valid_d = (state_d == SEND) || (state_d == GAP);
    done_d    = (state_d == DONE);
    d_d       = 1'b0;
    if (state_d == SEND)     d_d = PATTERN[idx_d];
    else if (state_d == GAP) d_d = fill_d;
    last_d = (state_d == SEND) && (idx_d == '0) &&
             ((pcnt_d + CNT_W'(1)) == rep_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gcnt_q    <= '0;
      pcnt_q    <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      fill_q    <= 1'b0;
      ready_q   <= 1'b1;
      d_q       <= 1'b0;
      d_valid_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      pcnt_q    <= pcnt_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      fill_q    <= fill_d;
      ready_q   <= ready_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign last    = last_q;
  assign done    = done_q;
  assign pat_cnt = pcnt_q;

endmodule

// File: doc/seq_1010_tx.md
Name: seq_1010_tx

Overview:
- Serial pattern transmitter. It emits framed bit streams made of a programmable number of PATTERN words (default 1010), MSB first, on a one-bit serial output.
- Consecutive words are separated by an optional run of filler bits.
- It is the driving end for the team's 1010 sequence detectors and is used as stimulus source and link-side generator.
- A start/ready/done handshake controls framing.

Parameters:
- PAT_W, 4, pattern width in bits (>=1).
- PATTERN, 4'b1010, pattern word, transmitted MSB first.
- CNT_W, 8, width of repeat count and pattern counter.
- GAP_W, 4, width of gap length.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous active-low reset.
- start  input  1  request a frame; sampled only when ready=1.
- repeat_cnt  input  CNT_W  number of patterns in the frame; latched on accepted start.
- gap_len  input  GAP_W  filler bits between patterns; latched on accepted start.
- filler  input  1  value driven during gap bits; latched on accepted start.
- abort  input  1  terminate the frame in progress.
- ready  output  1  high in IDLE only.
- d  output  1  serial data.
- d_valid  output  1  d carries a frame bit this cycle.
- last  output  1  final bit of final pattern.
- done  output  1  one-cycle pulse at normal frame completion.
- pat_cnt  output  CNT_W  patterns fully sent in the current or most recent frame.

Behaviour:
- Outputs are decoded from registered state, bit index and counters only. There is no combinational path from any input to any output.
- Reset: reset=0 at a rising edge forces IDLE, index=0, gap counter=0 and pat_cnt=0 from any state. The latched repeat_cnt, gap_len and filler are cleared.
  - Outputs after reset: d=0, d_valid=0, last=0, done=0, ready=1.
  - Reset mid-frame truncates the stream immediately, with no done pulse.
- FSM states:
  - IDLE: ready=1, d=0, d_valid=0.
    - start=1 with repeat_cnt!=0: latch inputs, pat_cnt<=0, index<=PAT_W-1, go to SEND.
    - start=1 with repeat_cnt==0: pat_cnt<=0, go to DONE; no bits are sent.
    - abort is ignored in IDLE.
  - SEND: d=PATTERN[index], d_valid=1. Index decrements each cycle.
    - At index==0: pat_cnt increments.
    - If pat_cnt+1==repeat, go to DONE.
    - Otherwise, if gap==0, go to SEND with index=PAT_W-1 (back-to-back patterns).
    - Otherwise go to GAP with gap counter=gap_len.
  - GAP: d=filler, d_valid=1. The counter decrements; at counter==1, go to SEND with index=PAT_W-1.
  - DONE: done=1, d_valid=0, d=0, ready=0 for exactly one cycle, then IDLE.
- last=1 only in SEND with index==0 on the final pattern.
- Latency: start sampled at edge N makes the first pattern bit valid in the cycle following edge N. done is high in the cycle after the last bit.
- Frame length in d_valid cycles = repeat*PAT_W + (repeat-1)*gap_len. d_valid is continuous with no holes inside a frame.
- start while ready=0 is ignored; it is not queued.
- abort=1 in SEND or GAP sends the FSM to IDLE at that edge: d_valid=0 next cycle, no done, no last. pat_cnt holds the count of patterns completed before the abort.
- reset has priority over abort, and abort has priority over normal transitions.
- pat_cnt holds its value in IDLE until the next accepted start.
- Inputs changing mid-frame have no effect; only the latched copies are used.

Test Plan:
- Reset, start with repeat=1, gap=0 -> d=1,0,1,0 on 4 consecutive valid cycles; last on the 4th; done the next cycle; pat_cnt=1; ready=1 after.
- repeat=3, gap_len=2, filler=0 -> 16 valid cycles carrying 1010 00 1010 00 1010; last on cycle 16 only; pat_cnt=3.
- repeat=2, gap=0, output fed to the 1010 non-overlapping detector -> 10101010 over 8 cycles; the detector reports exactly 2 hits.
- repeat=0 -> done pulses the cycle after start; d_valid never asserts; pat_cnt=0.
- repeat=5, abort in the 7th valid cycle -> d_valid=0 the next cycle; no done; pat_cnt=1; ready=1. A following start with repeat=1 sends 1010 normally.
- repeat=4, gap=3, filler=1: reset low during the 2nd gap bit -> all outputs 0 and ready=1 the next cycle. start pulses during an active frame produce no second frame.
